// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types, coin codes and pricing for the vending controller
package vending_pkg;

    // Controller states: three credit levels plus the change-return phase
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        C5     = 2'd1,
        C10    = 2'd2,
        RETURN = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam logic [5:0] PRICE = 6'd15;

    // Coin code to value in cents
    function automatic logic [5:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_NICKEL:  coin_value = 6'd5;
            COIN_DIME:    coin_value = 6'd10;
            COIN_QUARTER: coin_value = 6'd25;
            default:      coin_value = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/vending_machine.sv
// rtl/vending_machine.sv - single-product (15 cent) vending control FSM with nickel change return
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] money,
    output logic       dispense,
    output logic       change
);

    state_t     r_state;
    logic [1:0] r_cnt;        // change nickels still owed after the current pulse
    logic       r_dispense;
    logic       r_change;

    state_t     w_next_state;
    logic [1:0] w_next_cnt;
    logic       w_next_dispense;
    logic       w_next_change;
    logic [5:0] w_credit;
    logic [5:0] w_total;
    logic [2:0] w_owed;

    // Next-state and next-output decode; outputs are registered from these
    always_comb begin
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        w_next_dispense = 1'b0;
        w_next_change   = 1'b0;
        w_credit        = 6'd0;
        w_total         = 6'd0;
        w_owed          = 3'd0;

        case (r_state)
            C5:      w_credit = 6'd5;
            C10:     w_credit = 6'd10;
            default: w_credit = 6'd0;
        endcase

        if (r_state == RETURN) begin
            // Coins arriving here are dropped; just pay out the next nickel
            w_next_change = 1'b1;
            w_next_cnt    = r_cnt - 2'd1;
            if (r_cnt <= 2'd1) begin
                w_next_state = IDLE;
                w_next_cnt   = 2'd0;
            end
        end else begin
            w_total = w_credit + coin_value(money);
            if (w_total < PRICE) begin
                case (w_total)
                    6'd5:    w_next_state = C5;
                    6'd10:   w_next_state = C10;
                    default: w_next_state = IDLE;
                endcase
            end else begin
                // Totals are multiples of 5 in 15..35, so excess nickels are 0..4
                case (w_total)
                    6'd20:   w_owed = 3'd1;
                    6'd25:   w_owed = 3'd2;
                    6'd30:   w_owed = 3'd3;
                    6'd35:   w_owed = 3'd4;
                    default: w_owed = 3'd0;
                endcase
                w_next_dispense = 1'b1;
                w_next_change   = (w_owed != 3'd0);
                if (w_owed > 3'd1) begin
                    w_next_state = RETURN;
                    // First nickel goes out with the vend; the counter holds the rest
                    w_next_cnt   = w_owed[1:0] - 2'd1;
                end else begin
                    w_next_state = IDLE;
                    w_next_cnt   = 2'd0;
                end
            end
        end
    end

    // State, counter and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_dispense <= 1'b0;
            r_change   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_dispense <= w_next_dispense;
            r_change   <= w_next_change;
        end
    end

    assign dispense = r_dispense;
    assign change   = r_change;

endmodule

// File: tb/tb_vending_machine.sv
// tb/tb_vending_machine.sv - scoreboard bench for the vending controller with a credit/owed-change model
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] money = 2'b00;
    logic       dispense;
    logic       change;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];

    // Reference model state: cents inserted so far and nickels still to pay out
    int m_credit  = 0;
    int m_pending = 0;

    vending_machine dut (
        .clk      (clk),
        .rst      (rst),
        .money    (money),
        .dispense (dispense),
        .change   (change)
    );

    always #5 clk = ~clk;

    function automatic int cents(input logic [1:0] code);
        case (code)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one sampled coin and queue the outputs expected after that edge
    task automatic model_step(input logic [1:0] coin);
        logic d;
        logic c;
        int   total;
        int   owed;
        d = 1'b0;
        c = 1'b0;
        if (m_pending > 0) begin
            c = 1'b1;
            m_pending--;
        end else begin
            total = m_credit + cents(coin);
            if (total >= 15) begin
                owed      = (total - 15) / 5;
                d         = 1'b1;
                c         = (owed > 0);
                m_pending = (owed > 0) ? owed - 1 : 0;
                m_credit  = 0;
            end else begin
                m_credit = total;
            end
        end
        exp_q.push_back({d, c});
    endtask

    task automatic step(input logic [1:0] coin);
        @(negedge clk);
        money = coin;
        model_step(coin);
    endtask

    // Pull reset between edges and confirm outputs clear without waiting for a clock
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst   = 1'b0;
        money = 2'b00;
        #1;
        checks++;
        if (dispense !== 1'b0 || change !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_%s got dispense=%b change=%b need 0 0", tag, dispense, change);
        end
        m_credit  = 0;
        m_pending = 0;
        exp_q.delete();
        exp_q.push_back(2'b00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: after every rising edge compare the registered outputs with the oldest expectation
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({dispense, change} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got dispense,change=%b%b need %b", $time, dispense, change, e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dispense !== 1'b0 || change !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got dispense=%b change=%b need 0 0", dispense, change);
        end
        @(negedge clk);
        rst = 1'b1;

        // Dime + dime: vend with one nickel back
        step(2'b10); step(2'b10); step(2'b00);
        do_reset("a");
        // Three nickels vend exactly; the fourth only builds credit
        step(2'b01); step(2'b01); step(2'b01); step(2'b01); step(2'b00);
        do_reset("b");
        // Dime + quarter: vend plus four nickels
        step(2'b10); step(2'b11); step(2'b00); step(2'b00); step(2'b00); step(2'b00);
        // Same again with dimes offered during the return phase
        step(2'b10); step(2'b11); step(2'b10); step(2'b10); step(2'b10); step(2'b00);
        step(2'b01); step(2'b00);
        do_reset("c");
        // Dime, idle cycles, then a nickel completes the price
        step(2'b10);
        repeat (5) step(2'b00);
        step(2'b01); step(2'b00);
        // Reset in the middle of change return, then a nickel must not vend
        step(2'b10); step(2'b11); step(2'b00);
        do_reset("d");
        step(2'b01); step(2'b00); step(2'b00);

        // Randomized coin stream with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset("rnd");
            else
                step(2'($urandom_range(0, 3)));
        end

        step(2'b00); step(2'b00);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
